// File: rtl/vpu_lane_sequencer.sv
// Issues one vector instruction as 64-bit beats to a single VPU lane and
// returns the lane results to the VRF through a small result FIFO.
module vpu_lane_sequencer #(
  parameter int VL_W      = 7,
  parameter int RES_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_fu_i,
  input  logic [1:0]      req_vsew_i,
  input  logic [VL_W-1:0] req_vl_i,
  input  logic [4:0]      req_vd_i,
  output logic            lane_valid_o,
  output logic            lane_fu_o,
  output logic [1:0]      lane_vsew_o,
  output logic [VL_W-1:0] lane_beat_o,
  input  logic            lane_res_valid_i,
  input  logic            lane_res_en_i,
  input  logic [63:0]     lane_res_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_en_o,
  output logic [4:0]      wb_vd_o,
  output logic [VL_W-1:0] wb_beat_o,
  output logic [7:0]      wb_be_o,
  output logic [63:0]     wb_data_o,
  output logic            done_o
);

  localparam int CNT_W   = $clog2(RES_DEPTH + 1);
  localparam int PTR_W   = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int BYTES_W = VL_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic            en;
    logic [VL_W-1:0] beat;
    logic [7:0]      be;
    logic [63:0]     data;
  } res_entry_t;

  state_e state_q, state_d;

  logic            fu_q, fu_d;
  logic [1:0]      vsew_q, vsew_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [4:0]      vd_q, vd_d;
  logic [VL_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [VL_W-1:0] res_cnt_q, res_cnt_d;
  logic [VL_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  res_entry_t fifo_q [RES_DEPTH];
  res_entry_t push_entry;
  res_entry_t head;

  logic               accept;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic [CNT_W:0]     occupancy;
  logic [BYTES_W-1:0] vl_bytes;
  logic [VL_W-1:0]    nbeats;
  logic [VL_W-1:0]    last_beat;
  logic [7:0]         last_be;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(RES_DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  // Beat geometry of the latched instruction: total bytes, beat count and
  // the partial byte-enable pattern of the final beat.
  always_comb begin
    vl_bytes  = BYTES_W'(vl_q) << vsew_q;
    nbeats    = VL_W'((vl_bytes + BYTES_W'(7)) >> 3);
    last_beat = nbeats - VL_W'(1);
    last_be   = (vl_bytes[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << vl_bytes[2:0]);
  end

  // Credit: every beat issued but not yet written back holds one FIFO slot.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = occupancy < (CNT_W + 1)'(RES_DEPTH);

  assign accept = req_valid_i && req_ready_o;
  // A VALU result may arrive with its own issue while inflight_q is still 0.
  assign push   = lane_res_valid_i && (state_q == S_ISSUE || state_q == S_DRAIN) &&
                  (inflight_q != '0 || lane_valid_o);
  assign pop    = wb_valid_o && wb_ready_i;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of the others; comb blocks use blocking (=).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_vl_i == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issue_cnt_d == nbeats) state_d = S_DRAIN;
      S_DRAIN: if (wb_cnt_d == nbeats) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    lane_valid_o = (state_q == S_ISSUE) && (issue_cnt_q < nbeats) && credit_ok;
    done_o       = (state_q == S_DONE);
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    fu_d        = fu_q;
    vsew_d      = vsew_q;
    vl_d        = vl_q;
    vd_d        = vd_q;
    issue_cnt_d = issue_cnt_q + VL_W'(lane_valid_o);
    res_cnt_d   = res_cnt_q + VL_W'(push);
    wb_cnt_d    = wb_cnt_q + VL_W'(pop);
    inflight_d  = inflight_q + CNT_W'(lane_valid_o) - CNT_W'(push);
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (accept) begin
      fu_d        = req_fu_i;
      vsew_d      = req_vsew_i;
      vl_d        = req_vl_i;
      vd_d        = req_vd_i;
      issue_cnt_d = '0;
      res_cnt_d   = '0;
      wb_cnt_d    = '0;
      inflight_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fu_q        <= 1'b0;
      vsew_q      <= 2'd0;
      vl_q        <= '0;
      vd_q        <= 5'd0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      wb_cnt_q    <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      fu_q        <= fu_d;
      vsew_q      <= vsew_d;
      vl_q        <= vl_d;
      vd_q        <= vd_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // -------------------------------------------------------- result FIFO
  always_comb begin
    push_entry.en   = lane_res_en_i;
    push_entry.beat = res_cnt_q;
    push_entry.be   = (res_cnt_q == last_beat) ? last_be : 8'hFF;
    push_entry.data = lane_res_i;
  end

  // NOTE: storage is not reset; the count/pointers define validity and the
  // outputs below are zeroed while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    wb_valid_o = (fifo_cnt_q != '0);
    wb_en_o    = wb_valid_o && head.en;
    wb_beat_o  = wb_valid_o ? head.beat : '0;
    wb_be_o    = wb_valid_o ? head.be : 8'h00;
    wb_data_o  = wb_valid_o ? head.data : 64'd0;
  end

  assign lane_fu_o   = fu_q;
  assign lane_vsew_o = vsew_q;
  assign lane_beat_o = issue_cnt_q;
  assign wb_vd_o     = vd_q;

endmodule

// File: tb/tb_vpu_lane_sequencer.sv
// Directed bench for vpu_lane_sequencer: table of instructions run against a
// behavioural lane (VALU same-cycle, VMUL two-cycle) plus reset corner cases.
module tb_vpu_lane_sequencer;

  localparam int VL_W      = 7;
  localparam int RES_DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_fu_i;
  logic [1:0]      req_vsew_i;
  logic [VL_W-1:0] req_vl_i;
  logic [4:0]      req_vd_i;
  logic            lane_valid_o;
  logic            lane_fu_o;
  logic [1:0]      lane_vsew_o;
  logic [VL_W-1:0] lane_beat_o;
  logic            lane_res_valid_i;
  logic            lane_res_en_i;
  logic [63:0]     lane_res_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic            wb_en_o;
  logic [4:0]      wb_vd_o;
  logic [VL_W-1:0] wb_beat_o;
  logic [7:0]      wb_be_o;
  logic [63:0]     wb_data_o;
  logic            done_o;

  int n_chk = 0;
  int n_err = 0;

  vpu_lane_sequencer #(.VL_W(VL_W), .RES_DEPTH(RES_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_fu_i(req_fu_i), .req_vsew_i(req_vsew_i), .req_vl_i(req_vl_i), .req_vd_i(req_vd_i),
    .lane_valid_o(lane_valid_o), .lane_fu_o(lane_fu_o), .lane_vsew_o(lane_vsew_o),
    .lane_beat_o(lane_beat_o),
    .lane_res_valid_i(lane_res_valid_i), .lane_res_en_i(lane_res_en_i), .lane_res_i(lane_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_en_o(wb_en_o), .wb_vd_o(wb_vd_o),
    .wb_beat_o(wb_beat_o), .wb_be_o(wb_be_o), .wb_data_o(wb_data_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] data_of(input logic mul, input logic [VL_W-1:0] beat);
    return {(mul ? 16'hBEEF : 16'hCAFE), 41'd0, beat};
  endfunction

  function automatic logic en_of(input logic [VL_W-1:0] beat);
    return (beat % 3) != 2;
  endfunction

  // Behavioural lane: VALU answers combinationally, VMUL two cycles later.
  logic            s1_v = 1'b0, s2_v = 1'b0;
  logic [VL_W-1:0] s1_b = '0, s2_b = '0;
  logic [VL_W-1:0] res_beat;

  always @(posedge clk_i) begin
    s1_v <= lane_valid_o && lane_fu_o;
    s1_b <= lane_beat_o;
    s2_v <= s1_v;
    s2_b <= s1_b;
  end

  assign res_beat         = s2_v ? s2_b : lane_beat_o;
  assign lane_res_valid_i = (lane_valid_o && !lane_fu_o) || s2_v;
  assign lane_res_en_i    = en_of(res_beat);
  assign lane_res_i       = data_of(s2_v, res_beat);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            fu;
    logic [1:0]      vsew;
    logic [VL_W-1:0] vl;
    logic [4:0]      vd;
    int              stall;      // wb_ready_i low for this many cycles from first issue
    int              nbeats;
    logic [7:0]      last_be;
    int              wb_lat;     // cycles from first issue to first writeback
    int              stall_iss;  // beats issued by the last stalled cycle
  } vec_t;

  task automatic run_op(input vec_t v);
    int  issued = 0, written = 0, dones = 0, cyc = 0;
    int  first_iss = -1, last_iss = -1, first_wb = -1, stall_iss = -1;
    bit  hold_bad = 1'b0;
    logic [7:0] exp_be;
    @(negedge clk_i);
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_fu_i    = v.fu;
    req_vsew_i  = v.vsew;
    req_vl_i    = v.vl;
    req_vd_i    = v.vd;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    while (dones == 0 && cyc < 300) begin
      @(negedge clk_i);
      if (lane_fu_o !== v.fu || lane_vsew_o !== v.vsew) hold_bad = 1'b1;
      if (lane_valid_o) begin
        if (first_iss < 0) first_iss = cyc;
        check("credit", 64'((issued - written) < RES_DEPTH), 64'd1);
        check("lane_beat", 64'(lane_beat_o), 64'(issued));
        issued++;
        last_iss = cyc;
      end
      wb_ready_i = (first_iss >= 0 && cyc - first_iss < v.stall) ? 1'b0 : 1'b1;
      if (wb_valid_o && wb_ready_i) begin
        if (first_wb < 0) first_wb = cyc;
        exp_be = (written == v.nbeats - 1) ? v.last_be : 8'hFF;
        check("wb_beat", 64'(wb_beat_o), 64'(written));
        check("wb_be", 64'(wb_be_o), 64'(exp_be));
        check("wb_en", 64'(wb_en_o), 64'(en_of(VL_W'(written))));
        check("wb_data", wb_data_o, data_of(v.fu, VL_W'(written)));
        check("wb_vd", 64'(wb_vd_o), 64'(v.vd));
        written++;
      end
      if (v.stall > 0 && first_iss >= 0 && cyc - first_iss == v.stall - 1) stall_iss = issued;
      if (done_o) begin
        dones++;
        check("done_after_last_wb", 64'(written), 64'(v.nbeats));
      end
      cyc++;
    end
    wb_ready_i = 1'b1;
    check("done_seen", 64'(dones), 64'd1);
    check("issued_total", 64'(issued), 64'(v.nbeats));
    check("written_total", 64'(written), 64'(v.nbeats));
    check("fu_vsew_hold", 64'(hold_bad), 64'd0);
    check("wb_latency", 64'(first_wb - first_iss), 64'(v.wb_lat));
    if (v.stall == 0) check("issue_contiguous", 64'(last_iss - first_iss), 64'(v.nbeats - 1));
    else              check("stall_issued", 64'(stall_iss), 64'(v.stall_iss));
    @(negedge clk_i);
    check("done_single_pulse", 64'(done_o), 64'd0);
    check("ready_after_done", 64'(req_ready_o), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    check({tag, "_lane_valid"}, 64'(lane_valid_o), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_lane_misc"}, 64'({lane_fu_o, lane_vsew_o, lane_beat_o}), 64'd0);
    check({tag, "_wb_misc"}, 64'({wb_en_o, wb_vd_o, wb_beat_o, wb_be_o}), 64'd0);
    check({tag, "_wb_data"}, wb_data_o, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int n, guard;
    //          fu    vsew  vl     vd     stall nb lbe    lat stall_iss
    vecs[0] = '{1'b0, 2'd2, 7'd16, 5'd3,  0,    8, 8'hFF, 1,  0};
    vecs[1] = '{1'b1, 2'd3, 7'd3,  5'd7,  0,    3, 8'hFF, 3,  0};
    vecs[2] = '{1'b0, 2'd1, 7'd5,  5'd9,  0,    2, 8'h03, 1,  0};
    vecs[3] = '{1'b1, 2'd0, 7'd64, 5'd31, 10,   8, 8'hFF, 10, 4};
    vecs[4] = '{1'b0, 2'd0, 7'd13, 5'd1,  3,    2, 8'h1F, 3,  2};
    vecs[5] = '{1'b1, 2'd2, 7'd7,  5'd12, 0,    4, 8'h0F, 3,  0};

    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    req_fu_i    = 1'b0;
    req_vsew_i  = 2'd0;
    req_vl_i    = '0;
    req_vd_i    = 5'd0;
    wb_ready_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // vl == 0: straight to DONE, nothing issued or written back.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_fu_i    = 1'b0;
    req_vsew_i  = 2'd2;
    req_vl_i    = '0;
    req_vd_i    = 5'd4;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check("vl0_done", 64'(done_o), 64'd1);
    check("vl0_lane_valid", 64'(lane_valid_o), 64'd0);
    check("vl0_wb_valid", 64'(wb_valid_o), 64'd0);
    check("vl0_ready_low", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    check("vl0_done_end", 64'(done_o), 64'd0);
    check("vl0_ready_back", 64'(req_ready_o), 64'd1);

    // Reset with two VMUL beats in flight; the late result lands in IDLE.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_fu_i    = 1'b1;
    req_vsew_i  = 2'd3;
    req_vl_i    = 7'd4;
    req_vd_i    = 5'd5;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    n = 0;
    guard = 0;
    while (n < 2 && guard < 20) begin
      @(negedge clk_i);
      if (lane_valid_o) n++;
      guard++;
    end
    check("rst_pre_issues", 64'(n), 64'd2);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 check_reset_outputs("midop_reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op('{1'b0, 2'd3, 7'd8, 5'd2, 0, 8, 8'hFF, 1, 0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
